rv_bpu_gshare: RTL

Parametrised dynamic branch prediction unit: a gshare predictor (global history XOR PC into a table of saturating counters) plus a direct-mapped branch target buffer (BTB). It sits between IF (lookup, next-PC selection) and EX (resolution, table update, flush/redirect). Compared with the previous 2-bit/16-entry predictor it adds:
- configurable table depths and counter width;
- speculative global history with recovery;
- target prediction;
- no flush on correctly predicted `jal`/`jalr`;
- a mispredict counter.

---
 rtl/rv_bpu_pkg.sv | 18 +
 rtl/rv_bpu_btb.sv | 57 +++++
 rtl/rv_bpu_gshare.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rv_bpu_pkg.sv
// Shared encodings and width helpers for the gshare branch prediction unit.
package rv_bpu_pkg;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_COND = 2'd1;
  localparam logic [1:0] BR_JAL  = 2'd2;
  localparam logic [1:0] BR_JALR = 2'd3;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  // Tag covers every PC bit above the word offset and the table index.
  function automatic int tag_w(input int pc_w, input int depth);
    return pc_w - $clog2(depth) - 2;
  endfunction

endpackage

// File: rtl/rv_bpu_btb.sv
// Direct-mapped branch target buffer: one combinational read port, one write port.
module rv_bpu_btb
  import rv_bpu_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] rd_pc,
  output logic            rd_hit,
  output logic [PC_W-1:0] rd_target,
  output logic [1:0]      rd_type,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic [PC_W-1:0] wr_target,
  input  logic [1:0]      wr_type
);

  localparam int IW = idx_w(BTB_DEPTH);
  localparam int TW = tag_w(PC_W, BTB_DEPTH);

  logic [BTB_DEPTH-1:0] valid_q;
  logic [TW-1:0]        tag_q    [BTB_DEPTH];
  logic [PC_W-1:0]      target_q [BTB_DEPTH];
  logic [1:0]           type_q   [BTB_DEPTH];

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          unused_pc_bits;

  assign rd_idx         = rd_pc[IW+1:2];
  assign wr_idx         = wr_pc[IW+1:2];
  assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_pc[PC_W-1:IW+2]);
  assign rd_target = rd_hit ? target_q[rd_idx] : '0;
  assign rd_type   = rd_hit ? type_q[rd_idx] : BR_NONE;

  // Only the valid bits need clearing; payload is qualified by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_pc[PC_W-1:IW+2];
      target_q[wr_idx] <= wr_target;
      type_q[wr_idx]   <= wr_type;
    end
  end

endmodule

// File: rtl/rv_bpu_gshare.sv
// Gshare direction predictor with speculative global history, BTB target
// prediction and same-cycle EX mispredict detection.
module rv_bpu_gshare
  import rv_bpu_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 2,
  parameter int GHR_W     = 6,
  parameter int BTB_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid_i,
  input  logic [PC_W-1:0]  if_pc_i,
  output logic             if_hit_o,
  output logic             if_predict_o,
  output logic [PC_W-1:0]  if_target_o,
  output logic [GHR_W-1:0] if_ghr_o,
  input  logic             ex_valid_i,
  input  logic             ex_branch_i,
  input  logic             ex_jal_i,
  input  logic             ex_jalr_i,
  input  logic             ex_taken_i,
  input  logic [PC_W-1:0]  ex_pc_i,
  input  logic [PC_W-1:0]  ex_target_i,
  input  logic             ex_pred_taken_i,
  input  logic [PC_W-1:0]  ex_pred_target_i,
  input  logic [GHR_W-1:0] ex_ghr_i,
  output logic             ex_flush_o,
  output logic [PC_W-1:0]  ex_redirect_pc_o,
  output logic [31:0]      mispred_cnt_o
);

  localparam int               BHT_IW   = idx_w(BHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] c,
                                                  input logic up);
    if (up) return (c == CNT_MAX) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [BHT_IW-1:0] bht_index(input logic [PC_W-1:0]  pc,
                                                  input logic [GHR_W-1:0] g);
    return pc[BHT_IW+1:2] ^ BHT_IW'(g);
  endfunction

  function automatic logic [GHR_W-1:0] ghr_push(input logic [GHR_W-1:0] g,
                                                input logic b);
    return (g << 1) | GHR_W'(b);
  endfunction

  logic [CNT_W-1:0] bht_q [BHT_DEPTH];
  logic [GHR_W-1:0] ghr_q;
  logic [31:0]      mispred_cnt_q;

  logic             btb_hit;
  logic [PC_W-1:0]  btb_target;
  logic [1:0]       btb_type;
  logic [1:0]       ex_type;
  logic             eff_taken;
  logic             mispred;
  logic             spec_shift;
  logic [BHT_IW-1:0] rd_idx;
  logic [BHT_IW-1:0] wr_idx;

  rv_bpu_btb #(
    .PC_W      (PC_W),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (if_pc_i),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .rd_type   (btb_type),
    .wr_en     (ex_valid_i && eff_taken),
    .wr_pc     (ex_pc_i),
    .wr_target (ex_target_i),
    .wr_type   (ex_type)
  );

  // IF lookup: purely combinational off registered state.
  assign rd_idx       = bht_index(if_pc_i, ghr_q);
  assign if_hit_o     = btb_hit;
  assign if_target_o  = btb_target;
  assign if_ghr_o     = ghr_q;
  assign if_predict_o = if_valid_i && btb_hit &&
                        ((btb_type != BR_COND) || bht_q[rd_idx][CNT_W-1]);
  assign spec_shift   = if_valid_i && btb_hit && (btb_type == BR_COND);

  // EX resolve: jumps are always taken.
  assign eff_taken = ex_taken_i || ex_jal_i || ex_jalr_i;
  assign ex_type   = ex_jal_i ? BR_JAL : (ex_jalr_i ? BR_JALR : BR_COND);
  assign mispred   = ex_valid_i &&
                     ((eff_taken != ex_pred_taken_i) ||
                      (eff_taken && (ex_pred_target_i != ex_target_i)));
  assign ex_flush_o       = mispred;
  assign ex_redirect_pc_o = eff_taken ? ex_target_i : ex_pc_i + PC_W'(4);
  assign wr_idx           = bht_index(ex_pc_i, ex_ghr_i);
  assign mispred_cnt_o    = mispred_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CNT_INIT;
    end else if (ex_valid_i && ex_branch_i) begin
      bht_q[wr_idx] <= sat_update(bht_q[wr_idx], ex_taken_i);
    end
  end

  // Recovery from a resolved mispredict takes priority over the IF shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (mispred) begin
      ghr_q <= ex_branch_i ? ghr_push(ex_ghr_i, ex_taken_i) : ex_ghr_i;
    end else if (spec_shift) begin
      ghr_q <= ghr_push(ghr_q, if_predict_o);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_cnt_q <= '0;
    end else if (mispred && (mispred_cnt_q != '1)) begin
      mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

endmodule
